// File: rtl/sdu_pkg.sv
// Shared encodings for the debug unit: command opcodes, completion causes
// and the run-control state machine states.
package sdu_pkg;

  // Command opcodes carried on cmd_op; 5..7 are reserved.
  typedef enum logic [2:0] {
    OP_STEP   = 3'd0,
    OP_RUN    = 3'd1,
    OP_HALT   = 3'd2,
    OP_SET_BP = 3'd3,
    OP_CLR_BP = 3'd4
  } cmd_op_e;

  // Reasons reported on done_cause when a sequence finishes.
  typedef enum logic [1:0] {
    CAUSE_COUNT = 2'd0,
    CAUSE_BP    = 2'd1,
    CAUSE_HALT  = 2'd2,
    CAUSE_ERR   = 2'd3
  } done_cause_e;

  // Run-control states. HI/LO/CHK together form one CPU clock cycle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_RPT  = 3'd4
  } run_state_e;

  // True when the opcode is a HALT, the only command taken while clocking.
  function automatic logic is_halt(input logic [2:0] op);
    return op == 3'(OP_HALT);
  endfunction

endpackage

// File: rtl/bp_match.sv
// Combinational PC breakpoint comparator bank. Reports whether any enabled
// breakpoint equals the current PC and the lowest index that does.
module bp_match
  import sdu_pkg::*;
#(
  parameter int NUM_BP = 2
) (
  input  logic [NUM_BP-1:0][31:0] bp,
  input  logic [NUM_BP-1:0]       en,
  input  logic [31:0]             pc,
  output logic                    hit,
  output logic [1:0]              hit_idx
);

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (en[i] && (bp[i] == pc)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU clock sequencer for the debug unit. Turns STEP/RUN/HALT commands into
// clk_cpu pulses (3 clk per CPU cycle), stops on PC breakpoints and reports
// why it stopped over a ready/valid completion channel.
module cpu_run_ctrl
  import sdu_pkg::*;
#(
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  cmd_idx,
  input  logic [31:0] pc_chk,
  output logic        clk_cpu,
  output logic        busy,
  output logic        done_vld,
  input  logic        done_rdy,
  output logic [1:0]  done_cause,
  output logic [1:0]  done_bp,
  output logic [31:0] cyc_cnt
);

  localparam logic [2:0]       NUM_BP_L = 3'(NUM_BP);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  run_state_e               state;
  logic                     idle_q;
  logic                     run_mode;
  logic                     halt_pend;
  logic [CNT_W-1:0]         remain;
  logic [NUM_BP-1:0][31:0]  bp_q;
  logic [NUM_BP-1:0]        en_q;

  logic                     bp_hit;
  logic [1:0]               bp_hit_idx;
  logic                     idx_ok;
  logic                     halt_acc;
  logic [CNT_W-1:0]         step_n;

  bp_match #(
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .bp      (bp_q),
    .en      (en_q),
    .pc      (pc_chk),
    .hit     (bp_hit),
    .hit_idx (bp_hit_idx)
  );

  // Any command is taken in IDLE; while clocking only a HALT is taken, and
  // nothing is taken while a completion is waiting to be collected.
  assign cmd_rdy  = idle_q | (busy & is_halt(cmd_op));
  assign halt_acc = cmd_vld & busy & is_halt(cmd_op);
  assign idx_ok   = {1'b0, cmd_idx} < NUM_BP_L;
  assign step_n   = (cmd_arg[CNT_W-1:0] == '0) ? ONE : cmd_arg[CNT_W-1:0];

  // Run-control FSM; every output is registered alongside its state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idle_q     <= 1'b1;
      run_mode   <= 1'b0;
      halt_pend  <= 1'b0;
      remain     <= '0;
      bp_q       <= '0;
      en_q       <= '0;
      clk_cpu    <= 1'b0;
      busy       <= 1'b0;
      done_vld   <= 1'b0;
      done_cause <= 2'd0;
      done_bp    <= 2'd0;
      cyc_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_vld) begin
            case (cmd_op)
              OP_STEP: begin
                remain   <= step_n;
                run_mode <= 1'b0;
                state    <= ST_HI;
                idle_q   <= 1'b0;
                busy     <= 1'b1;
                clk_cpu  <= 1'b1;
              end
              OP_RUN: begin
                run_mode <= 1'b1;
                state    <= ST_HI;
                idle_q   <= 1'b0;
                busy     <= 1'b1;
                clk_cpu  <= 1'b1;
              end
              OP_HALT: begin
                state      <= ST_RPT;
                idle_q     <= 1'b0;
                done_vld   <= 1'b1;
                done_cause <= CAUSE_HALT;
                done_bp    <= 2'd0;
              end
              OP_SET_BP, OP_CLR_BP: begin
                if (idx_ok) begin
                  for (int i = 0; i < NUM_BP; i++) begin
                    if (cmd_idx == 2'(i)) begin
                      if (cmd_op == 3'(OP_SET_BP)) begin
                        bp_q[i] <= cmd_arg;
                        en_q[i] <= 1'b1;
                      end else begin
                        en_q[i] <= 1'b0;
                      end
                    end
                  end
                end else begin
                  state      <= ST_RPT;
                  idle_q     <= 1'b0;
                  done_vld   <= 1'b1;
                  done_cause <= CAUSE_ERR;
                  done_bp    <= 2'd0;
                end
              end
              default: begin
                state      <= ST_RPT;
                idle_q     <= 1'b0;
                done_vld   <= 1'b1;
                done_cause <= CAUSE_ERR;
                done_bp    <= 2'd0;
              end
            endcase
          end
        end

        ST_HI: begin
          state   <= ST_LO;
          clk_cpu <= 1'b0;
          cyc_cnt <= cyc_cnt + 32'd1;
          if (halt_acc) begin
            halt_pend <= 1'b1;
          end
        end

        ST_LO: begin
          state <= ST_CHK;
          if (halt_acc) begin
            halt_pend <= 1'b1;
          end
        end

        ST_CHK: begin
          if (halt_pend || halt_acc) begin
            state      <= ST_RPT;
            busy       <= 1'b0;
            done_vld   <= 1'b1;
            done_cause <= CAUSE_HALT;
            done_bp    <= 2'd0;
          end else if (bp_hit) begin
            state      <= ST_RPT;
            busy       <= 1'b0;
            done_vld   <= 1'b1;
            done_cause <= CAUSE_BP;
            done_bp    <= bp_hit_idx;
          end else if (!run_mode && (remain == ONE)) begin
            state      <= ST_RPT;
            busy       <= 1'b0;
            done_vld   <= 1'b1;
            done_cause <= CAUSE_COUNT;
            done_bp    <= 2'd0;
          end else begin
            if (!run_mode) begin
              remain <= remain - ONE;
            end
            state   <= ST_HI;
            clk_cpu <= 1'b1;
          end
        end

        ST_RPT: begin
          if (done_rdy) begin
            state     <= ST_IDLE;
            idle_q    <= 1'b1;
            done_vld  <= 1'b0;
            run_mode  <= 1'b0;
            halt_pend <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          idle_q   <= 1'b1;
          busy     <= 1'b0;
          clk_cpu  <= 1'b0;
          done_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: step/run/halt sequencing, breakpoints,
// error causes, completion backpressure and asynchronous reset.
module tb_cpu_run_ctrl;
  import sdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_arg = '0;
  logic [1:0]  cmd_idx = '0;
  logic [31:0] pc_chk = '0;
  logic        clk_cpu;
  logic        busy;
  logic        done_vld;
  logic        done_rdy = 1'b0;
  logic [1:0]  done_cause;
  logic [1:0]  done_bp;
  logic [31:0] cyc_cnt;

  int  errCount = 0;
  int  checkCount = 0;
  int  pulses = 0;
  int  runBase = 0;
  bit  pcModel = 1'b0;
  time riseT = 0;
  int  widthErr = 0;
  int  lat;
  int  base;

  cpu_run_ctrl #(.NUM_BP(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_idx    (cmd_idx),
    .pc_chk     (pc_chk),
    .clk_cpu    (clk_cpu),
    .busy       (busy),
    .done_vld   (done_vld),
    .done_rdy   (done_rdy),
    .done_cause (done_cause),
    .done_bp    (done_bp),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  // Count CPU clock pulses and, when enabled, advance a toy PC by 4 per pulse.
  always @(posedge clk_cpu) begin
    pulses++;
    riseT = $time;
    if (pcModel) pc_chk = 32'((pulses - runBase - 1) * 4);
  end

  // Every completed clk_cpu high phase must last exactly one clk period.
  always @(negedge clk_cpu) begin
    if (!rst && (($time - riseT) != 10)) widthErr++;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for a single clk edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] arg, input logic [1:0] idx);
    @(negedge clk);
    cmd_op  = op;
    cmd_arg = arg;
    cmd_idx = idx;
    cmd_vld = 1'b1;
    @(posedge clk);
    #1 cmd_vld = 1'b0;
  endtask

  // Count falling clk edges after acceptance until done_vld is seen.
  task automatic waitDone(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_vld && cyc < limit);
    if (!done_vld) checkOutput("done_timeout", {31'b0, done_vld}, 32'd1);
  endtask

  task automatic ackDone();
    @(negedge clk);
    done_rdy = 1'b1;
    @(posedge clk);
    #1 done_rdy = 1'b0;
    checkOutput("done_drop", {31'b0, done_vld}, 32'd0);
  endtask

  initial begin
    // Reset values, observed while reset is held.
    #12;
    checkOutput("rst_clk_cpu", {31'b0, clk_cpu}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done_vld", {31'b0, done_vld}, 32'd0);
    checkOutput("rst_cause", {30'b0, done_cause}, 32'd0);
    checkOutput("rst_bp", {30'b0, done_bp}, 32'd0);
    checkOutput("rst_cyc", cyc_cnt, 32'd0);
    checkOutput("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // STEP 3, no breakpoints: 3 pulses, done_vld 10 clk after acceptance.
    base = pulses;
    applyStimulus(OP_STEP, 32'd3, 2'd0);
    waitDone(100, lat);
    checkOutput("step3_latency", 32'(lat), 32'd10);
    checkOutput("step3_pulses", 32'(pulses - base), 32'd3);
    checkOutput("step3_cause", {30'b0, done_cause}, 32'(CAUSE_COUNT));
    checkOutput("step3_cyc", cyc_cnt, 32'd3);
    // Completion held under backpressure, further commands refused.
    cmd_op = OP_STEP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_vld", {31'b0, done_vld}, 32'd1);
      checkOutput("hold_cause", {30'b0, done_cause}, 32'(CAUSE_COUNT));
      checkOutput("hold_rdy", {31'b0, cmd_rdy}, 32'd0);
    end
    checkOutput("hold_pulses", 32'(pulses - base), 32'd3);
    ackDone();

    // Breakpoint 1 at 0x10, RUN with PC stepping by 4 from 0.
    applyStimulus(OP_SET_BP, 32'h0000_0010, 2'd1);
    @(negedge clk);
    checkOutput("setbp_no_done", {31'b0, done_vld}, 32'd0);
    checkOutput("setbp_rdy", {31'b0, cmd_rdy}, 32'd1);
    pc_chk  = 32'h0;
    runBase = pulses;
    pcModel = 1'b1;
    applyStimulus(OP_RUN, 32'd0, 2'd0);
    waitDone(100, lat);
    pcModel = 1'b0;
    checkOutput("bp_pulses", 32'(pulses - runBase), 32'd5);
    checkOutput("bp_cause", {30'b0, done_cause}, 32'(CAUSE_BP));
    checkOutput("bp_idx", {30'b0, done_bp}, 32'd1);
    checkOutput("bp_cyc", cyc_cnt, 32'd8);
    ackDone();

    // RUN, then HALT while the second pulse is high.
    pc_chk = 32'h100;
    base = pulses;
    applyStimulus(OP_RUN, 32'd0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("halt_in_hi", {31'b0, clk_cpu}, 32'd1);
    cmd_op  = OP_HALT;
    cmd_vld = 1'b1;
    #1 checkOutput("halt_rdy", {31'b0, cmd_rdy}, 32'd1);
    @(posedge clk);
    #1 cmd_vld = 1'b0;
    waitDone(100, lat);
    checkOutput("halt_cause", {30'b0, done_cause}, 32'(CAUSE_HALT));
    repeat (5) @(negedge clk);
    checkOutput("halt_pulses", 32'(pulses - base), 32'd2);
    checkOutput("pulse_width", 32'(widthErr), 32'd0);
    ackDone();

    // STEP 0 behaves as STEP 1.
    base = pulses;
    applyStimulus(OP_STEP, 32'd0, 2'd0);
    waitDone(100, lat);
    checkOutput("step0_latency", 32'(lat), 32'd4);
    checkOutput("step0_pulses", 32'(pulses - base), 32'd1);
    checkOutput("step0_cause", {30'b0, done_cause}, 32'(CAUSE_COUNT));
    ackDone();

    // Out-of-range breakpoint index and reserved opcode report errors.
    base = pulses;
    applyStimulus(OP_SET_BP, 32'h20, 2'd3);
    waitDone(20, lat);
    checkOutput("badidx_latency", 32'(lat), 32'd1);
    checkOutput("badidx_cause", {30'b0, done_cause}, 32'(CAUSE_ERR));
    ackDone();
    applyStimulus(3'd5, 32'd0, 2'd0);
    waitDone(20, lat);
    checkOutput("rsvd_cause", {30'b0, done_cause}, 32'(CAUSE_ERR));
    checkOutput("err_pulses", 32'(pulses - base), 32'd0);
    ackDone();

    // Both breakpoints at 0x20 with PC already there: one cycle, lowest index.
    applyStimulus(OP_SET_BP, 32'h20, 2'd0);
    applyStimulus(OP_SET_BP, 32'h20, 2'd1);
    pc_chk = 32'h20;
    base = pulses;
    applyStimulus(OP_STEP, 32'd5, 2'd0);
    waitDone(100, lat);
    checkOutput("dual_pulses", 32'(pulses - base), 32'd1);
    checkOutput("dual_cause", {30'b0, done_cause}, 32'(CAUSE_BP));
    checkOutput("dual_idx", {30'b0, done_bp}, 32'd0);
    ackDone();

    // Clearing bp0 leaves bp1 as the match.
    applyStimulus(OP_CLR_BP, 32'd0, 2'd0);
    applyStimulus(OP_STEP, 32'd2, 2'd0);
    waitDone(100, lat);
    checkOutput("clr_idx", {30'b0, done_bp}, 32'd1);
    checkOutput("clr_cyc", cyc_cnt, 32'd13);
    ackDone();

    // HALT from IDLE reports immediately without clocking.
    base = pulses;
    applyStimulus(OP_HALT, 32'd0, 2'd0);
    waitDone(20, lat);
    checkOutput("idlehalt_cause", {30'b0, done_cause}, 32'(CAUSE_HALT));
    checkOutput("idlehalt_pulses", 32'(pulses - base), 32'd0);
    ackDone();

    // Reset while clk_cpu is high drops it at once.
    pc_chk = 32'h100;
    applyStimulus(OP_RUN, 32'd0, 2'd0);
    checkOutput("rsthi_pre", {31'b0, clk_cpu}, 32'd1);
    rst = 1'b1;
    #1 checkOutput("rsthi_clk_cpu", {31'b0, clk_cpu}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during LO of a RUN clears state and breakpoint enables.
    applyStimulus(OP_SET_BP, 32'h20, 2'd1);
    applyStimulus(OP_RUN, 32'd0, 2'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstlo_clk_cpu", {31'b0, clk_cpu}, 32'd0);
    checkOutput("rstlo_busy", {31'b0, busy}, 32'd0);
    checkOutput("rstlo_done_vld", {31'b0, done_vld}, 32'd0);
    checkOutput("rstlo_rdy", {31'b0, cmd_rdy}, 32'd1);
    checkOutput("rstlo_cyc", cyc_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pc_chk = 32'h20;
    applyStimulus(OP_STEP, 32'd1, 2'd0);
    waitDone(100, lat);
    checkOutput("rstlo_en_cleared", {30'b0, done_cause}, 32'(CAUSE_COUNT));
    ackDone();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

- Sequences the debug unit's CPU clock.
- Turns single-step, multi-step, run and halt commands from the debug command processor into `clk_cpu` pulses.
- Stops on PC breakpoints and reports the stop cause back through a ready/valid completion channel.
- Sits between the command processor and the CPU under test, replacing ad-hoc `clk_cpu` toggling.

## Interface
- `NUM_BP`, 2: number of PC breakpoint registers (1..4).
- `CNT_W`, 16: step-count width.
- `clk` input 1: single clock; the same divided clock that drives the command processor.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_vld` input 1: command valid.
- `cmd_rdy` output 1: command ready.
- `cmd_op` input 3: 0 STEP, 1 RUN, 2 HALT, 3 SET_BP, 4 CLR_BP; 5..7 reserved.
- `cmd_arg` input 32: step count (low `CNT_W` bits) or breakpoint PC.
- `cmd_idx` input 2: breakpoint index.
- `pc_chk` input 32: CPU PC, sampled after each CPU cycle.
- `clk_cpu` output 1: generated CPU clock.
- `busy` output 1: CPU is being clocked.
- `done_vld` output 1: completion valid.
- `done_rdy` input 1: completion ready.
- `done_cause` output 2: 0 count reached, 1 breakpoint hit, 2 halted by command, 3 error.
- `done_bp` output 2: index of the breakpoint that was hit.
- `cyc_cnt` output 32: total CPU cycles since reset, wraps.

## Operation
States: IDLE, HI, LO, CHK, RPT.

- **Command acceptance**
  - `cmd_rdy` = 1 in IDLE.
  - `cmd_rdy` = 1 in HI/LO/CHK only for HALT.
  - `cmd_rdy` = 0 in RPT.
- **STEP n**
  - Loads `remain` = n; n = 0 is treated as 1.
  - IDLE→HI.
- **RUN**
  - Sets `run_mode`; no count limit.
  - IDLE→HI.
- **One CPU cycle**
  - HI: `clk_cpu` = 1 for one `clk`.
  - LO: `clk_cpu` = 0 for one `clk`.
  - CHK: compare, decrement, decide; `clk_cpu` = 0.
  - Each CPU cycle therefore takes exactly 3 `clk`.
  - `cyc_cnt` increments on HI→LO.
- **CHK priority (first match wins)**
  - Pending halt → cause 2.
  - Any enabled `bp[i]` == `pc_chk` → cause 1, `done_bp` = lowest matching i.
  - Not `run_mode` and `remain` == 1 → cause 0.
  - Otherwise decrement `remain` (STEP mode only) and go to HI.
- **HALT**
  - Accepted in HI or LO: sets `halt_pend`, so the current CPU cycle always completes (no runt pulse).
  - Accepted in CHK: takes effect in that same CHK.
  - Accepted in IDLE: goes straight to RPT with cause 2.
- **SET_BP / CLR_BP**
  - Accepted only in IDLE.
  - Write `bp[idx]` = `cmd_arg` and set `en[idx]` = 1, or clear `en[idx]`.
  - No completion is reported.
  - `idx` ≥ `NUM_BP` → RPT with cause 3; `bp`/`en` unchanged.
- Reserved op in IDLE → RPT with cause 3.
- Breakpoints are checked after a cycle, never before the first cycle: a STEP/RUN issued while `pc_chk` already equals an enabled bp still executes at least one cycle.
- **RPT**
  - `done_vld` = 1; cause and bp index held stable.
  - On `done_vld` & `done_rdy`: clear `run_mode` and `halt_pend`, go to IDLE.

## Timing
- **Reset values**
  - State IDLE.
  - `clk_cpu` 0, `busy` 0, `done_vld` 0, `done_cause` 0, `done_bp` 0.
  - `cyc_cnt` 0, all `en` 0, `cmd_rdy` 1.
  - `rst` mid-pulse forces `clk_cpu` low immediately (asynchronous).
- **Outputs and latency**
  - All outputs are registered.
  - `clk_cpu` rises the `clk` edge after STEP/RUN acceptance.
  - `busy` = 1 in HI/LO/CHK.
  - `done_vld` asserts the `clk` after CHK.
  - STEP n completion latency: 3n+1 clocks from acceptance to `done_vld`.
- **Handshakes**
  - A transfer completes when vld & rdy on a rising edge.
  - `done_*` is held until accepted.
- **Width rules**
  - `remain` is `CNT_W` bits; the maximum step count is 2^CNT_W − 1.
  - `cyc_cnt` wraps 0xFFFFFFFF→0.

## Structure
- Shared package `sdu_pkg`:
  - `cmd_op` encodings.
  - `done_cause` encodings.
  - State enum.
- Sub-module `bp_match`:
  - Combinational comparator bank over `NUM_BP` registers.
  - Outputs `hit` and lowest-index `hit_idx`.

## Test plan
- STEP 3 with no bps → exactly 3 `clk_cpu` pulses; `done_vld` 10 clk after acceptance; cause 0; `cyc_cnt` = 3.
- SET_BP idx1 = 0x0000_0010, then RUN with `pc_chk` stepping 0,4,8,0x0C,0x10 → stop after 5th pulse; cause 1; `done_bp` = 1.
- RUN, then HALT issued while in HI → current pulse completes fully, then cause 2; no further pulses; `clk_cpu` high time is always 1 clk.
- STEP 0 → one pulse, cause 0; SET_BP idx 3 with `NUM_BP` = 2 → cause 3, no pulse.
- Both bp0 and bp1 = 0x20 → `done_bp` = 0.
- Assert `rst` during LO of a RUN → `clk_cpu` 0, state IDLE, `en` cleared, `done_vld` 0.
- Hold `done_rdy` = 0 for 5 clk → `done_vld` and `done_cause` stable; STEP refused (`cmd_rdy` = 0).
